miner_work_dispatcher: RTL and testbench

Sequences a bank of N_CORES fpgaminer_top hashing cores from one work source. It accepts a work unit (midstate + 96-bit tail) through a valid/ready handshake and splits the 32-bit nonce space evenly across the cores. It pulses the cores' reset, runs them for a bounded time, and arbitrates their golden-nonce pulses into one valid/ready result stream. It sits between the host/UART work interface and the replicated miner cores.

---
 rtl/miner_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/miner_work_dispatcher.sv | 175 +++++++++++++++++
 tb/tb_miner_work_dispatcher.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared widths, dispatcher FSM states and the per-core nonce-base helper
// for the miner work dispatcher slice.
package miner_pkg;

    localparam int NONCE_W     = 32;
    localparam int MIDSTATE_W  = 256;
    localparam int WORK_DATA_W = 96;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_EXHAUSTED = 2'd3
    } state_t;

    // Start nonce for core idx: idx * (2^32 / n_cores), i.e. {idx, zeros}.
    function automatic logic [NONCE_W-1:0] nonce_base(input int idx, input int n_cores);
        logic [63:0] step;
        logic [63:0] prod;
        step = 64'h1_0000_0000 / 64'(n_cores);
        prod = 64'(idx) * step;
        return NONCE_W'(prod);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant searched from
// last_grant+1; last_grant only moves when the grant is consumed (advance).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] last_grant;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_grant) + k) % N;
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // Reset to N-1 so the first search starts at core 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= IDX_W'(N - 1);
        end else if (advance && grant_any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/miner_work_dispatcher.sv
// Feeds one work unit to a bank of hashing cores with a split nonce space,
// bounds the run time and merges golden-nonce pulses into one result stream.
module miner_work_dispatcher
    import miner_pkg::*;
#(
    parameter int          N_CORES        = 4,
    parameter int          CORE_IDX_W     = 2,
    parameter int          RESET_CYCLES   = 2,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h4000_0000
) (
    input  logic                         hash_clk,
    input  logic                         reset,
    input  logic                         work_valid,
    output logic                         work_ready,
    input  logic [MIDSTATE_W-1:0]        work_midstate,
    input  logic [WORK_DATA_W-1:0]       work_data,
    output logic [MIDSTATE_W-1:0]        core_midstate,
    output logic [WORK_DATA_W-1:0]       core_work_data,
    output logic [NONCE_W*N_CORES-1:0]   core_nonce_min,
    output logic                         core_reset,
    input  logic [N_CORES-1:0]           core_new_nonce,
    input  logic [NONCE_W*N_CORES-1:0]   core_golden_nonce,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [NONCE_W-1:0]           result_nonce,
    output logic [CORE_IDX_W-1:0]        result_core,
    output logic                         busy,
    output logic                         exhausted,
    output logic                         overflow,
    output state_t                       dbg_state
);

    // Both streams are valid/ready: a beat moves on a clock edge where
    // valid && ready; the producer holds valid and payload stable until then.

    state_t state, state_next;
    logic [31:0] load_cnt;
    logic [31:0] tcnt;
    logic        xfer;

    logic [N_CORES-1:0]    pend_q;
    logic [N_CORES-1:0]    pend_after;
    logic [N_CORES-1:0]    capture;
    logic [NONCE_W-1:0]    hold_q [N_CORES];
    logic [N_CORES-1:0]    grant;
    logic [CORE_IDX_W-1:0] grant_idx;
    logic                  grant_any;
    logic                  out_free;
    logic                  take;
    logic                  drop;

    assign xfer = work_valid && work_ready;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        work_ready = 1'b1;
        core_reset = 1'b1;
        busy       = 1'b0;
        exhausted  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                work_ready = 1'b0;
                busy       = 1'b1;
                if (load_cnt == 32'(RESET_CYCLES - 1)) state_next = ST_RUN;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                busy       = 1'b1;
                // New work wins over the timeout in the same cycle.
                if (xfer) begin
                    state_next = ST_LOAD;
                end else if (tcnt == TIMEOUT_CYCLES - 32'd1) begin
                    state_next = ST_EXHAUSTED;
                end
            end
            ST_EXHAUSTED: begin
                exhausted = 1'b1;
                if (xfer) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            load_cnt <= '0;
            tcnt     <= '0;
        end else if (xfer) begin
            load_cnt <= '0;
            tcnt     <= '0;
        end else if (state == ST_LOAD) begin
            load_cnt <= load_cnt + 32'd1;
        end else if (state == ST_RUN) begin
            tcnt <= tcnt + 32'd1;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            core_midstate  <= '0;
            core_work_data <= '0;
            core_nonce_min <= '0;
        end else if (xfer) begin
            core_midstate  <= work_midstate;
            core_work_data <= work_data;
            for (int i = 0; i < N_CORES; i++) begin
                core_nonce_min[NONCE_W*i +: NONCE_W] <= nonce_base(i, N_CORES);
            end
        end
    end

    rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (CORE_IDX_W)
    ) u_arb (
        .clk       (hash_clk),
        .reset     (reset),
        .req       (pend_q),
        .advance   (take),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign out_free = !result_valid || result_ready;
    assign take     = out_free && grant_any && !xfer;

    // A slot emptied this cycle may refill in the same cycle without overflow.
    assign pend_after = take ? (pend_q & ~grant) : pend_q;
    assign capture    = (state == ST_RUN && !xfer) ? (core_new_nonce & ~pend_after) : '0;
    assign drop       = (state == ST_RUN) && !xfer && |(core_new_nonce & pend_after);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            pend_q       <= '0;
            result_valid <= 1'b0;
            result_nonce <= '0;
            result_core  <= '0;
            overflow     <= 1'b0;
            for (int i = 0; i < N_CORES; i++) hold_q[i] <= '0;
        end else begin
            if (drop) overflow <= 1'b1;
            if (xfer) begin
                pend_q       <= '0;
                result_valid <= 1'b0;
            end else begin
                pend_q <= pend_after | capture;
                for (int i = 0; i < N_CORES; i++) begin
                    if (capture[i]) hold_q[i] <= core_golden_nonce[NONCE_W*i +: NONCE_W];
                end
                if (take) begin
                    result_valid <= 1'b1;
                    result_nonce <= hold_q[grant_idx];
                    result_core  <= grant_idx;
                end else if (result_ready) begin
                    result_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_miner_work_dispatcher.sv
// Directed bench for miner_work_dispatcher: load, result arbitration,
// overflow, timeout, reload priority and mid-run reset.
module tb_miner_work_dispatcher;
    import miner_pkg::*;

    localparam int N = 4;

    logic          hash_clk;
    logic          reset;
    logic          work_valid;
    logic          work_ready;
    logic [255:0]  work_midstate;
    logic [95:0]   work_data;
    logic [255:0]  core_midstate;
    logic [95:0]   core_work_data;
    logic [127:0]  core_nonce_min;
    logic          core_reset;
    logic [N-1:0]  core_new_nonce;
    logic [127:0]  core_golden_nonce;
    logic          result_valid;
    logic          result_ready;
    logic [31:0]   result_nonce;
    logic [1:0]    result_core;
    logic          busy;
    logic          exhausted;
    logic          overflow;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] GEN_MID  = 256'h4719f91b_0c5d6a3e_8f2b71d4_a6e39c05_5b1d8e72_e03f4a69_1c7e2db8_bc909a33;
    localparam logic [95:0]  GEN_DATA = 96'hffff001d_29ab5f49_4b1e5e4a;
    localparam logic [255:0] MID2     = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    localparam logic [95:0]  DATA2    = 96'h11223344_55667788_99aabbcc;

    miner_work_dispatcher #(
        .N_CORES        (N),
        .CORE_IDX_W     (2),
        .RESET_CYCLES   (2),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .work_valid        (work_valid),
        .work_ready        (work_ready),
        .work_midstate     (work_midstate),
        .work_data         (work_data),
        .core_midstate     (core_midstate),
        .core_work_data    (core_work_data),
        .core_nonce_min    (core_nonce_min),
        .core_reset        (core_reset),
        .core_new_nonce    (core_new_nonce),
        .core_golden_nonce (core_golden_nonce),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_nonce      (result_nonce),
        .result_core       (result_core),
        .busy              (busy),
        .exhausted         (exhausted),
        .overflow          (overflow),
        .dbg_state         (dbg_state)
    );

    // Clock / reset
    initial hash_clk = 1'b0;
    always #5 hash_clk = ~hash_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_work(input logic [255:0] m, input logic [95:0] d);
        work_midstate = m;
        work_data     = d;
        work_valid    = 1'b1;
        tick();
        work_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse(input int core, input logic [31:0] nonce);
        core_new_nonce[core]               = 1'b1;
        core_golden_nonce[32*core +: 32]   = nonce;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, 256'(core_reset), 256'(1));
        check({tag, "_work_ready"}, 256'(work_ready), 256'(1));
        check({tag, "_rv"}, 256'(result_valid), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_exh"}, 256'(exhausted), 256'(0));
        check({tag, "_ovf"}, 256'(overflow), 256'(0));
        check({tag, "_mid"}, core_midstate, 256'(0));
        check({tag, "_data"}, 256'(core_work_data), 256'(0));
        check({tag, "_nmin"}, 256'(core_nonce_min), 256'(0));
        check({tag, "_state"}, 256'(dbg_state), 256'(ST_IDLE));
    endtask

    initial begin
        reset             = 1'b1;
        work_valid        = 1'b0;
        work_midstate     = '0;
        work_data         = '0;
        core_new_nonce    = '0;
        core_golden_nonce = '0;
        result_ready      = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Genesis work load
        work_midstate = GEN_MID;
        work_data     = GEN_DATA;
        work_valid    = 1'b1;
        check("ready_idle", 256'(work_ready), 256'(1));
        tick();
        work_valid = 1'b0;
        check("load_state", 256'(dbg_state), 256'(ST_LOAD));
        check("load_ready", 256'(work_ready), 256'(0));
        check("load_creset1", 256'(core_reset), 256'(1));
        check("load_mid", core_midstate, GEN_MID);
        check("load_data", 256'(core_work_data), 256'(GEN_DATA));
        check("load_nmin", 256'(core_nonce_min), 256'(128'hc0000000_80000000_40000000_00000000));
        tick();
        check("load_creset2", 256'(core_reset), 256'(1));
        tick();
        check("run_creset", 256'(core_reset), 256'(0));
        check("run_busy", 256'(busy), 256'(1));
        check("run_state", 256'(dbg_state), 256'(ST_RUN));

        // Cores 0,1,3 together, consumer always ready
        result_ready = 1'b1;
        pulse(0, 32'ha0000000);
        pulse(1, 32'hb1111111);
        pulse(3, 32'hd3333333);
        tick();
        core_new_nonce = '0;
        check("rr_lat1", 256'(result_valid), 256'(0));
        tick();
        check("rr0_v", 256'(result_valid), 256'(1));
        check("rr0_n", 256'(result_nonce), 256'(32'ha0000000));
        check("rr0_c", 256'(result_core), 256'(0));
        tick();
        check("rr1_n", 256'(result_nonce), 256'(32'hb1111111));
        check("rr1_c", 256'(result_core), 256'(1));
        tick();
        check("rr3_n", 256'(result_nonce), 256'(32'hd3333333));
        check("rr3_c", 256'(result_core), 256'(3));
        tick();
        check("rr_empty", 256'(result_valid), 256'(0));

        // Core 2 result with backpressure
        result_ready = 1'b0;
        pulse(2, 32'h9962e301);
        tick();
        core_new_nonce = '0;
        check("c2_lat1", 256'(result_valid), 256'(0));
        tick();
        check("c2_v", 256'(result_valid), 256'(1));
        check("c2_n", 256'(result_nonce), 256'(32'h9962e301));
        check("c2_c", 256'(result_core), 256'(2));
        tick();
        check("c2_hold_v", 256'(result_valid), 256'(1));
        check("c2_hold_n", 256'(result_nonce), 256'(32'h9962e301));
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("c2_clear", 256'(result_valid), 256'(0));

        // New work while a result is out and another is pending
        pulse(0, 32'hc0ffee00);
        tick();
        core_new_nonce = '0;
        pulse(3, 32'hdead0003);
        tick();
        core_new_nonce = '0;
        check("pre_reload_v", 256'(result_valid), 256'(1));
        check("pre_reload_c", 256'(result_core), 256'(0));
        work_midstate = MID2;
        work_data     = DATA2;
        work_valid    = 1'b1;
        tick();
        work_valid = 1'b0;
        check("reload_rv", 256'(result_valid), 256'(0));
        check("reload_state", 256'(dbg_state), 256'(ST_LOAD));
        check("reload_mid", core_midstate, MID2);
        pulse(2, 32'h12345678);
        tick();
        core_new_nonce = '0;
        tick();
        check("reload_run", 256'(dbg_state), 256'(ST_RUN));
        tick();
        tick();
        check("reload_no_stale", 256'(result_valid), 256'(0));

        // Overflow: N1 moves out, N2 refills same cycle, N3 dropped
        load_work(MID2, DATA2);
        pulse(1, 32'h11111111);
        tick();
        pulse(1, 32'h22222222);
        tick();
        check("ovf_refill", 256'(overflow), 256'(0));
        check("ovf_out_n1", 256'(result_nonce), 256'(32'h11111111));
        pulse(1, 32'h33333333);
        tick();
        core_new_nonce = '0;
        check("ovf_set", 256'(overflow), 256'(1));
        check("ovf_keep_n1", 256'(result_nonce), 256'(32'h11111111));
        result_ready = 1'b1;
        tick();
        check("ovf_n2_v", 256'(result_valid), 256'(1));
        check("ovf_n2_n", 256'(result_nonce), 256'(32'h22222222));
        check("ovf_n2_c", 256'(result_core), 256'(1));
        tick();
        result_ready = 1'b0;
        check("ovf_drained", 256'(result_valid), 256'(0));

        // Timeout after 16 RUN cycles
        load_work(GEN_MID, GEN_DATA);
        for (int k = 0; k < 15; k++) tick();
        check("to_run15_exh", 256'(exhausted), 256'(0));
        check("to_run15_cr", 256'(core_reset), 256'(0));
        tick();
        check("to_exh", 256'(exhausted), 256'(1));
        check("to_exh_cr", 256'(core_reset), 256'(1));
        check("to_exh_busy", 256'(busy), 256'(0));
        check("to_exh_ready", 256'(work_ready), 256'(1));
        check("to_ovf_sticky", 256'(overflow), 256'(1));
        tick();
        check("to_exh_hold", 256'(dbg_state), 256'(ST_EXHAUSTED));
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        check("to_reload_exh", 256'(exhausted), 256'(0));
        check("to_reload_state", 256'(dbg_state), 256'(ST_LOAD));
        tick();
        tick();

        // Transfer on the final RUN cycle beats the timeout
        for (int k = 0; k < 15; k++) tick();
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        check("prio_state", 256'(dbg_state), 256'(ST_LOAD));
        check("prio_exh", 256'(exhausted), 256'(0));
        tick();
        tick();

        // Synchronous reset mid-RUN
        pulse(1, 32'h0badf00d);
        tick();
        core_new_nonce = '0;
        tick();
        check("mr_rv_before", 256'(result_valid), 256'(1));
        reset = 1'b1;
        tick();
        check_reset_values("mr");
        reset = 1'b0;
        tick();
        check("mr_after_state", 256'(dbg_state), 256'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
